// File: rtl/cpu_mem_arbiter.sv
// Single-port unified program/data memory for the accumulator CPU, shared by the
// program loader, CPU data port and instruction fetch under fixed priority with fetch ageing.
module cpu_mem_arbiter #(
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [7:0]    ld_rdata,

    input  logic          dt_req,
    input  logic          dt_we,
    input  logic [AW-1:0] dt_addr,
    input  logic [7:0]    dt_wdata,
    output logic          dt_gnt,
    output logic          dt_rvalid,
    output logic [7:0]    dt_rdata,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [7:0]    if_rdata,

    output logic          busy
);

    localparam int         DEPTH   = 1 << AW;
    localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

    logic [7:0]    mem [DEPTH];
    logic [3:0]    age;
    logic          promote;
    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic [7:0]    acc_wdata;
    logic [7:0]    acc_rdata;

    // A starved fetch jumps ahead of both the loader and the data port for one grant.
    always_comb begin
        promote = if_req && (age == AGE_MAX);
        ld_gnt  = ld_req && !promote;
        dt_gnt  = dt_req && !ld_req && !promote;
        if_gnt  = if_req && (promote || (!ld_req && !dt_req));
        busy    = ld_gnt || dt_gnt || if_gnt;
    end

    always_comb begin
        acc_addr  = if_addr;
        acc_we    = 1'b0;
        acc_wdata = 8'h00;
        if (ld_gnt) begin
            acc_addr  = ld_addr;
            acc_we    = ld_we;
            acc_wdata = ld_wdata;
        end else if (dt_gnt) begin
            acc_addr  = dt_addr;
            acc_we    = dt_we;
            acc_wdata = dt_wdata;
        end
    end

    assign acc_rdata = mem[acc_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (busy && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    // Read data is captured per requester so each port keeps its last byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_rvalid <= 1'b0;
            dt_rvalid <= 1'b0;
            if_rvalid <= 1'b0;
            ld_rdata  <= 8'h00;
            dt_rdata  <= 8'h00;
            if_rdata  <= 8'h00;
        end else begin
            ld_rvalid <= ld_gnt && !ld_we;
            dt_rvalid <= dt_gnt && !dt_we;
            if_rvalid <= if_gnt;
            if (ld_gnt && !ld_we) ld_rdata <= acc_rdata;
            if (dt_gnt && !dt_we) dt_rdata <= acc_rdata;
            if (if_gnt)           if_rdata <= acc_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age <= 4'd0;
        end else if (!if_req || if_gnt) begin
            age <= 4'd0;
        end else if (age != AGE_MAX) begin
            age <= age + 4'd1;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: a behavioural model predicts grants and read
// responses; a separate monitor pops expected reads and checks rvalid/rdata every cycle.
module tb_cpu_mem_arbiter;

    localparam int AW       = 5;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_wdata = 8'h00;
    logic          ld_gnt, ld_rvalid;
    logic [7:0]    ld_rdata;
    logic          dt_req = 1'b0, dt_we = 1'b0;
    logic [AW-1:0] dt_addr = '0;
    logic [7:0]    dt_wdata = 8'h00;
    logic          dt_gnt, dt_rvalid;
    logic [7:0]    dt_rdata;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [7:0]    if_rdata;
    logic          busy;

    cpu_mem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
        .dt_gnt(dt_gnt), .dt_rvalid(dt_rvalid), .dt_rdata(dt_rdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         who;   // 0 loader, 1 data, 2 fetch
        logic [7:0] data;
        int         cyc;
    } rd_t;

    rd_t        q[$];
    logic [7:0] m_mem [DEPTH];
    logic [7:0] exp_rd [3];
    int         m_age = 0;
    logic [2:0] m_gnt = 3'b000;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 3; i++) exp_rd[i] = 8'h00;
        m_age = 0;
        m_gnt = 3'b000;
    endtask

    always @(posedge clk) cyc++;

    // Reference model: evaluated mid-cycle on the inputs that the next edge will sample.
    always @(negedge clk) begin
        logic       promote;
        logic [2:0] eg;
        if (!reset) begin
            promote = if_req && (m_age == MAX_WAIT);
            if (promote)     eg = 3'b001;
            else if (ld_req) eg = 3'b100;
            else if (dt_req) eg = 3'b010;
            else if (if_req) eg = 3'b001;
            else             eg = 3'b000;
            chk("grant", {28'd0, ld_gnt, dt_gnt, if_gnt, busy}, {28'd0, eg, |eg});
            m_gnt = eg;
            if (eg[2]) begin
                if (ld_we) m_mem[ld_addr] = ld_wdata;
                else q.push_back('{0, m_mem[ld_addr], cyc});
            end
            if (eg[1]) begin
                if (dt_we) m_mem[dt_addr] = dt_wdata;
                else q.push_back('{1, m_mem[dt_addr], cyc});
            end
            if (eg[0]) q.push_back('{2, m_mem[if_addr], cyc});
            if (!if_req || eg[0]) m_age = 0;
            else if (m_age < MAX_WAIT) m_age = m_age + 1;
        end
    end

    // Monitor: a read predicted before edge N must show rvalid during the cycle after edge N.
    always @(negedge clk) begin
        logic [2:0] ev;
        rd_t        e;
        if (!reset) begin
            ev = 3'b000;
            while (q.size() > 0 && q[0].cyc < cyc - 1) begin
                e = q.pop_front();
                chk("missed_rvalid_who", 32'(e.who), 32'hFFFF_FFFF);
            end
            if (q.size() > 0 && q[0].cyc == cyc - 1) begin
                e = q.pop_front();
                ev[2 - e.who] = 1'b1;
                exp_rd[e.who] = e.data;
            end
            chk("rvalid", {29'd0, ld_rvalid, dt_rvalid, if_rvalid}, {29'd0, ev});
            chk("ld_rdata", {24'd0, ld_rdata}, {24'd0, exp_rd[0]});
            chk("dt_rdata", {24'd0, dt_rdata}, {24'd0, exp_rd[1]});
            chk("if_rdata", {24'd0, if_rdata}, {24'd0, exp_rd[2]});
        end
    end

    task automatic drive(input logic lr, input logic lw, input logic [AW-1:0] la, input logic [7:0] ldv,
                         input logic dr, input logic dw, input logic [AW-1:0] da, input logic [7:0] ddv,
                         input logic ir, input logic [AW-1:0] ia);
        ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ldv;
        dt_req = dr; dt_we = dw; dt_addr = da; dt_wdata = ddv;
        if_req = ir; if_addr = ia;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        idle(2);

        // Loader write then fetch read of the same byte.
        drive(1, 1, 5'd3, 8'hA5, 0, 0, 0, 8'h00, 0, 0);
        drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 5'd3);
        idle(2);

        // Three-way contention resolved ld > dt > if.
        drive(1, 0, 5'd5, 8'h00, 1, 0, 5'd6, 8'h00, 1, 5'd7);
        drive(0, 0, 0, 8'h00, 1, 0, 5'd6, 8'h00, 1, 5'd7);
        drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 5'd7);
        idle(2);

        // Continuous data reads starve fetch until ageing promotes it.
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 8'h00, 1, 0, 5'd0, 8'h00, 1, 5'd3);
        idle(2);

        // Data write/read at the top address.
        drive(0, 0, 0, 8'h00, 1, 1, 5'd31, 8'h3C, 0, 0);
        drive(0, 0, 0, 8'h00, 1, 0, 5'd31, 8'h00, 0, 0);
        idle(2);

        // Preload then back-to-back fetches.
        drive(1, 1, 5'd0, 8'h11, 0, 0, 0, 8'h00, 0, 0);
        drive(1, 1, 5'd1, 8'h22, 0, 0, 0, 8'h00, 0, 0);
        drive(1, 1, 5'd2, 8'h33, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, AW'(i));
        idle(2);

        // Randomised traffic; each requester holds its request until granted.
        for (int n = 0; n < 1500; n++) begin
            if (!ld_req || m_gnt[2]) begin
                ld_req = ($urandom_range(3) == 0);
                ld_we = 1'($urandom_range(1)); ld_addr = AW'($urandom); ld_wdata = 8'($urandom);
            end
            if (!dt_req || m_gnt[1]) begin
                dt_req = ($urandom_range(1) == 0);
                dt_we = 1'($urandom_range(1)); dt_addr = AW'($urandom); dt_wdata = 8'($urandom);
            end
            if (!if_req || m_gnt[0]) begin
                if_req = ($urandom_range(3) != 0);
                if_addr = AW'($urandom);
            end
            @(posedge clk); #1;
        end
        idle(2);

        // Reset in the cycle after a data read grant.
        drive(0, 0, 0, 8'h00, 1, 1, 5'd9, 8'h5A, 0, 0);
        drive(0, 0, 0, 8'h00, 1, 0, 5'd9, 8'h00, 0, 0);
        #1 reset = 1'b1;
        ld_req = 0; dt_req = 0; if_req = 0; ld_we = 0; dt_we = 0;
        clear_model();
        @(negedge clk);
        chk("reset_dt_rvalid", {31'd0, dt_rvalid}, 32'd0);
        chk("reset_dt_rdata", {24'd0, dt_rdata}, 32'd0);
        @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        for (int a = 0; a < DEPTH; a++) drive(1, 0, AW'(a), 8'h00, 0, 0, 0, 8'h00, 0, 0);
        idle(3);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Owns the 8-bit-wide unified program/data memory of the tiny accumulator CPU and shares its single port between three requesters. The requesters are the external program loader, the CPU data port (LD/ST), and the CPU instruction fetch. It uses fixed priority with an anti-starvation age counter on fetch. Reads return registered data one cycle after grant.

Parameters:
AW, 5, address width; memory depth is 2**AW bytes.
MAX_WAIT, 4, consecutive denied fetch-request cycles after which fetch is promoted to top priority (1..15).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ld_req  input  1  loader request
ld_we  input  1  loader write enable (1 = write, 0 = read)
ld_addr  input  AW  loader address
ld_wdata  input  8  loader write data
ld_gnt  output  1  loader granted this cycle (combinational)
ld_rvalid  output  1  loader read data valid (registered pulse)
ld_rdata  output  8  loader read data
dt_req  input  1  CPU data request
dt_we  input  1  CPU data write enable
dt_addr  input  AW  CPU data address
dt_wdata  input  8  CPU data write data
dt_gnt  output  1  CPU data granted
dt_rvalid  output  1  CPU data read valid
dt_rdata  output  8  CPU data read data
if_req  input  1  fetch request (read only)
if_addr  input  AW  fetch address
if_gnt  output  1  fetch granted
if_rvalid  output  1  fetch data valid
if_rdata  output  8  fetch instruction byte
busy  output  1  any grant this cycle

Behaviour:
- Reset (asynchronous):
  - All memory bytes cleared to 0x00.
  - All *_rvalid = 0; all *_rdata = 0x00; age counter = 0.
  - Gnt outputs follow the combinational rule below and are 0 while all reqs are 0.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it samples gnt = 1 at a rising edge.
  - The access occurs on that edge.
  - Req may drop or change the cycle after the grant.
- Grant rule (combinational, exactly one or zero gnt per cycle):
  - If age == MAX_WAIT and if_req: fetch wins.
  - Else priority is ld > dt > if.
  - busy = OR of the gnts.
- Write (granted, we = 1): mem[addr] <= wdata at the edge. Rvalid does not pulse.
- Read (granted, we = 0, or any fetch):
  - *_rdata <= mem[addr] at the grant edge.
  - *_rvalid = 1 for exactly the following cycle, then 0.
  - Rdata holds its value until that requester's next read.
- Latency: 1 cycle from grant edge to rvalid. Back-to-back reads by the same requester give rvalid on consecutive cycles.
- Write followed by a read of the same address on the next granted cycle returns the new data. No bypass is needed, because the port is single.
- Age counter:
  - Increments (saturating at MAX_WAIT) each edge where if_req = 1 and if_gnt = 0.
  - Clears to 0 on an edge with if_gnt = 1 or if_req = 0.
- Promoted fetch pre-empts a simultaneous ld/dt request. That requester simply waits; its pending request is not lost.
- Addresses wrap naturally modulo 2**AW. There is no out-of-range condition.
- Reset asserted mid-operation:
  - Pending rvalid is suppressed; no pulse follows reset release.
  - Any write on the same edge as reset assertion is discarded.

Test Plan:
- After reset, ld writes 0xA5 to addr 3, then fetch reads addr 3 → if_gnt on the request cycle; if_rvalid = 1 for 1 cycle next; if_rdata = 0xA5.
- ld_req, dt_req and if_req all asserted with age 0 → ld_gnt only. On the next cycle with ld_req dropped → dt_gnt. Then → if_gnt.
- dt_req held high continuously (reads to addr 0) while if_req is held → if_gnt on the 5th contended cycle (MAX_WAIT = 4). dt_gnt resumes on the next cycle. Age reads 0 after the fetch grant.
- dt writes 0x3C to addr 31, then dt reads addr 31 on the next cycle → dt_rvalid pulse with 0x3C. ld_rdata and if_rdata are unchanged.
- Fetch reads addresses 0,1,2 on consecutive cycles after the loader preloads 0x11, 0x22, 0x33 → if_rvalid high for 3 consecutive cycles with data 0x11, 0x22, 0x33.
- Reset asserted in the cycle after a dt read grant → dt_rvalid stays 0, dt_rdata = 0x00, and every memory location reads 0x00 afterwards.
